// File: rtl/write_back_arbiter.sv
// write_back_arbiter
//   Shares one write-back port into a small register bank between NUM_REQ
//   requesters. A round-robin arbiter picks one requester per cycle; the
//   granted write lands in the bank on the next rising edge and is echoed
//   on the registered wb_* outputs.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   clr       synchronous bank clear; blocks grants and wins over any write
//   req       per-requester write request, held until granted
//   req_addr  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data  packed data, requester i at [i*DATA_W +: DATA_W]
//   gnt       one-hot grant, combinational, same cycle as req
//   rd_addr   read address
//   rd_data   combinational bank read data
//   wb_valid  a write committed on the last edge
//   wb_addr   address of the last commit
//   wb_data   data of the last commit
//
// Optional feature (macro WRITE_BACK_ARBITER_BYPASS_EN):
//   when defined, rd_data forwards the granted data in the grant cycle if the
//   granted address matches rd_addr (zero-latency read-after-write).

module write_back_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      wb_valid,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [DATA_W-1:0] bank     [DEPTH];

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  rr_next;
    logic              gnt_any;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    // Unpack the flat request buses into per-requester arrays.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Round-robin search starting at rr_ptr; first pending requester wins.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!rst && !clr) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = (32'(rr_ptr) + k) % NUM_REQ;
                if (!gnt_any && req[IDX_W'(cand)]) begin
                    gnt_any              = 1'b1;
                    gnt_idx              = IDX_W'(cand);
                    gnt[IDX_W'(cand)]    = 1'b1;
                end
            end
        end
    end

    assign gnt_addr = addr_arr[gnt_idx];
    assign gnt_data = data_arr[gnt_idx];

    // Pointer moves just past the winner so it becomes lowest priority next.
    assign rr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

    // Bank, round-robin pointer and write-back echo; clr outranks a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                bank[ADDR_W'(j)] <= '0;
            end
            rr_ptr   <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (clr) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                bank[ADDR_W'(j)] <= '0;
            end
            wb_valid <= 1'b0;
        end else if (gnt_any) begin
            bank[gnt_addr] <= gnt_data;
            rr_ptr         <= rr_next;
            wb_valid       <= 1'b1;
            wb_addr        <= gnt_addr;
            wb_data        <= gnt_data;
        end else begin
            wb_valid <= 1'b0;
        end
    end

    // Read port; gnt_any is already suppressed by clr and rst.
`ifdef WRITE_BACK_ARBITER_BYPASS_EN
    assign rd_data = (gnt_any && (gnt_addr == rd_addr)) ? gnt_data : bank[rd_addr];
`else
    assign rd_data = bank[rd_addr];
`endif

endmodule

// File: tb/tb_write_back_arbiter.sv
// Testbench for write_back_arbiter (NUM_REQ=4, DATA_W=8, ADDR_W=2).
module tb_write_back_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [3:0]  req;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [1:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        wb_valid;
    logic [1:0]  wb_addr;
    logic [7:0]  wb_data;

    always #5 clk = ~clk;

    write_back_arbiter #(
        .NUM_REQ(4),
        .DATA_W (8),
        .ADDR_W (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .req     (req),
        .req_addr(req_addr),
        .req_data(req_data),
        .gnt     (gnt),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wb_valid(wb_valid),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        clr;
        logic [1:0]  rd;
        logic [3:0]  gnt;
    } vec_t;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } wb_t;

    vec_t       vt[$];
    wb_t        sbq[$];
    logic [7:0] mbank[4];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [7:0] a, input logic [31:0] d,
                                input logic c, input logic [1:0] ra, input logic [3:0] g);
        vec_t v;
        v.req = r; v.addr = a; v.data = d; v.clr = c; v.rd = ra; v.gnt = g;
        return v;
    endfunction

    function automatic int idx_of(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic logic [1:0] slot_addr(input logic [7:0] a, input int i);
        logic [7:0] s;
        s = a >> (2 * i);
        return s[1:0];
    endfunction

    function automatic logic [7:0] slot_data(input logic [31:0] d, input int i);
        logic [31:0] s;
        s = d >> (8 * i);
        return s[7:0];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) mbank[i] = 8'h00;
    endtask

    // One cycle: drive at posedge+1, check comb outputs, then check the echo.
    task automatic do_step(input vec_t v, input string nm);
        int         gi;
        logic [1:0] ga;
        logic [7:0] gd;
        logic [7:0] exp_rd;
        wb_t        e;
        req = v.req; req_addr = v.addr; req_data = v.data; clr = v.clr; rd_addr = v.rd;
        #2;
        gi = idx_of(v.gnt);
        ga = 2'd0;
        gd = 8'h00;
        exp_rd = mbank[v.rd];
        if (gi >= 0) begin
            ga = slot_addr(v.addr, gi);
            gd = slot_data(v.data, gi);
        end
`ifdef WRITE_BACK_ARBITER_BYPASS_EN
        if (gi >= 0 && ga == v.rd) exp_rd = gd;
`endif
        chk({nm, " gnt"}, 32'(gnt), 32'(v.gnt));
        chk({nm, " rd_data"}, 32'(rd_data), 32'(exp_rd));
        if (gi >= 0) begin
            e.addr = ga;
            e.data = gd;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({nm, " wb_valid"}, 32'(wb_valid), 32'd1);
            chk({nm, " wb_addr"}, 32'(wb_addr), 32'(e.addr));
            chk({nm, " wb_data"}, 32'(wb_data), 32'(e.data));
        end else begin
            chk({nm, " wb_valid"}, 32'(wb_valid), 32'd0);
        end
        if (v.clr) clear_model();
        else if (gi >= 0) mbank[ga] = gd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Fairness: each requester writes its own address, then re-requests.
        vt.push_back(mk(4'b1111, 8'hE4, 32'h43322110, 1'b0, 2'd0, 4'b0001));
        vt.push_back(mk(4'b1111, 8'hE4, 32'h43322150, 1'b0, 2'd0, 4'b0010));
        vt.push_back(mk(4'b1111, 8'hE4, 32'h43326150, 1'b0, 2'd1, 4'b0100));
        vt.push_back(mk(4'b1111, 8'hE4, 32'h43726150, 1'b0, 2'd2, 4'b1000));
        vt.push_back(mk(4'b1111, 8'hE4, 32'h83726150, 1'b0, 2'd3, 4'b0001));
        vt.push_back(mk(4'b0000, 8'h00, 32'h0,        1'b0, 2'd0, 4'b0000));
        vt.push_back(mk(4'b0000, 8'h00, 32'h0,        1'b0, 2'd1, 4'b0000));
        vt.push_back(mk(4'b0000, 8'h00, 32'h0,        1'b0, 2'd2, 4'b0000));
        vt.push_back(mk(4'b0000, 8'h00, 32'h0,        1'b0, 2'd3, 4'b0000));
        // Single requester 2 writes A5 to addr 2.
        vt.push_back(mk(4'b0100, 8'h20, 32'h00A50000, 1'b0, 2'd2, 4'b0100));
        vt.push_back(mk(4'b0000, 8'h00, 32'h0,        1'b0, 2'd2, 4'b0000));
        // Move rr_ptr to 0, then requesters 1 and 3 both write addr 0.
        vt.push_back(mk(4'b1000, 8'hC0, 32'h99000000, 1'b0, 2'd3, 4'b1000));
        vt.push_back(mk(4'b1010, 8'h00, 32'h33001100, 1'b0, 2'd0, 4'b0010));
        vt.push_back(mk(4'b1000, 8'h00, 32'h33001100, 1'b0, 2'd0, 4'b1000));
        vt.push_back(mk(4'b0000, 8'h00, 32'h0,        1'b0, 2'd0, 4'b0000));
        // Clear with a pending request; the request is served afterwards.
        vt.push_back(mk(4'b0010, 8'h08, 32'h00007700, 1'b1, 2'd2, 4'b0000));
        vt.push_back(mk(4'b0010, 8'h08, 32'h00007700, 1'b0, 2'd2, 4'b0010));
        vt.push_back(mk(4'b0000, 8'h00, 32'h0,        1'b0, 2'd2, 4'b0000));
        vt.push_back(mk(4'b0000, 8'h00, 32'h0,        1'b0, 2'd0, 4'b0000));
        vt.push_back(mk(4'b0000, 8'h00, 32'h0,        1'b0, 2'd3, 4'b0000));
        // Requester 0 writes 5A to addr 1 while reading addr 1 (rr_ptr=2, wraps).
        vt.push_back(mk(4'b0001, 8'h01, 32'h0000005A, 1'b0, 2'd1, 4'b0001));
        vt.push_back(mk(4'b0000, 8'h00, 32'h0,        1'b0, 2'd1, 4'b0000));

        // Power-on reset with all requests pending.
        rst = 1'b1; clr = 1'b0; req = 4'b1111; req_addr = 8'hE4;
        req_data = 32'hF4E3D2C1; rd_addr = 2'd0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("por gnt", 32'(gnt), 32'd0);
        chk("por wb_valid", 32'(wb_valid), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            chk($sformatf("por rd%0d", a), 32'(rd_data), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) do_step(vt[i], $sformatf("vec%0d", i));

        // Reset asserted mid-operation, right after a commit, with a grant in flight.
        req = 4'b1111; req_addr = 8'hE4; req_data = 32'hF4E3D2C1; clr = 1'b0; rd_addr = 2'd1;
        #2;
        chk("mid gnt0", 32'(gnt), 32'b0010);
        @(posedge clk); #1;
        chk("mid wb_valid", 32'(wb_valid), 32'd1);
        chk("mid wb_addr", 32'(wb_addr), 32'd1);
        chk("mid wb_data", 32'(wb_data), 32'hD2);
        chk("mid rd1", 32'(rd_data), 32'hD2);
        chk("mid gnt1", 32'(gnt), 32'b0100);
        #2;
        rst = 1'b1;
        #1;
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_addr", 32'(wb_addr), 32'd0);
        chk("rst wb_data", 32'(wb_data), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            chk($sformatf("rst rd%0d", a), 32'(rd_data), 32'd0);
        end
        @(posedge clk); #1;
        chk("rst hold gnt", 32'(gnt), 32'd0);
        chk("rst hold wb_valid", 32'(wb_valid), 32'd0);
        rst = 1'b0;
        clear_model();
        do_step(mk(4'b1111, 8'hE4, 32'hF4E3D2C1, 1'b0, 2'd0, 4'b0001), "post_rst");
        do_step(mk(4'b0000, 8'h00, 32'h0,        1'b0, 2'd0, 4'b0000), "post_rst_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
